// File: rtl/ex_mem_stage_pkg.sv
// ---------------------------------------------------------------------------
// ex_mem_stage_pkg
// Shared pipeline definitions for the EX/MEM boundary.
//   DATA_W_DEF / ADDR_W_DEF : default widths of result data / dest address
//   wb_t                    : writeback triple {addr, data, en}
//   WB_NOP                  : all-zero writeback triple
//   REG_ZERO                : architectural zero register (never forwarded)
// ---------------------------------------------------------------------------
package ex_mem_stage_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] data;
        logic                  en;
    } wb_t;

    localparam wb_t                   WB_NOP   = '0;
    localparam logic [ADDR_W_DEF-1:0] REG_ZERO = '0;

endpackage : ex_mem_stage_pkg

// File: rtl/ex_mem_stage_skid_buf2.sv
// ---------------------------------------------------------------------------
// skid_buf2
// Generic 2-entry valid/ready FIFO buffer. in_ready depends on registered
// occupancy only, so downstream back-pressure never reaches the upstream
// side combinationally. Output is registered (no bypass).
// Ports:
//   clk, reset (async, active-low), flush (sync, clears everything)
//   in_valid / in_ready / in_data    : upstream handshake + payload
//   out_valid / out_ready / out_data : downstream handshake + head payload
//   tail_valid / tail_data           : second (younger) entry, only built
//                                      when EX_MEM_FWD_EN is defined
// ---------------------------------------------------------------------------
module skid_buf2 #(
    parameter int W = 38
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
`ifdef EX_MEM_FWD_EN
    output logic         tail_valid,
    output logic [W-1:0] tail_data,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    // slot0 is always the head; slot1 holds the younger entry when count==2.
    // Unoccupied slots are kept at zero so an empty buffer presents zeros.
    logic [1:0]   count;
    logic [W-1:0] slot0;
    logic [W-1:0] slot1;
    logic         push;
    logic         pop;

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign out_data  = out_valid ? slot0 : '0;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

`ifdef EX_MEM_FWD_EN
    assign tail_valid = (count == 2'd2);
    assign tail_data  = slot1;
`endif

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    // NOTE: the storage slots are reset along with count because an empty
    // buffer must present all-zero payload, not stale data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= 2'd0;
            slot0 <= '0;
            slot1 <= '0;
        end else if (flush) begin
            count <= 2'd0;
            slot0 <= '0;
            slot1 <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) slot0 <= in_data;
                    else               slot1 <= in_data;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    // Shift younger entry to head; slot1 is zero when count==1.
                    slot0 <= slot1;
                    slot1 <= '0;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    // Only reachable with count==1: new entry replaces head.
                    slot0 <= in_data;
                end
                default: ;
            endcase
        end
    end

endmodule : skid_buf2

// File: rtl/ex_mem_stage.sv
// ---------------------------------------------------------------------------
// ex_mem_stage
// Registered EX->MEM pipeline stage built on a 2-entry skid buffer.
// Ports:
//   clk, reset (async, active-low), flush (sync, highest priority)
//   ex_valid / ex_ready / ex_addr / ex_data / ex_en     : EX side
//   mem_valid / mem_ready / mem_addr / mem_data / mem_en : MEM side
// Optional macro EX_MEM_FWD_EN adds:
//   id_raddr (in), fwd_hit (out), fwd_data (out) : forwarding lookup of the
//   youngest buffered enabled write to id_raddr (register zero excluded).
// ---------------------------------------------------------------------------
module ex_mem_stage
    import ex_mem_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [ADDR_W-1:0] ex_addr,
    input  logic [DATA_W-1:0] ex_data,
    input  logic              ex_en,
`ifdef EX_MEM_FWD_EN
    input  logic [ADDR_W-1:0] id_raddr,
    output logic              fwd_hit,
    output logic [DATA_W-1:0] fwd_data,
`endif
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_en
);

    // Parameterised twin of the package writeback triple.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              en;
    } entry_t;

    localparam int PAYLOAD_W = $bits(entry_t);

    entry_t in_entry;
    entry_t head;

    assign in_entry = '{addr: ex_addr, data: ex_data, en: ex_en};

`ifdef EX_MEM_FWD_EN
    logic   tail_valid;
    entry_t tail;
`endif

    skid_buf2 #(
        .W (PAYLOAD_W)
    ) u_buf (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (ex_valid),
        .in_ready   (ex_ready),
        .in_data    (in_entry),
`ifdef EX_MEM_FWD_EN
        .tail_valid (tail_valid),
        .tail_data  (tail),
`endif
        .out_valid  (mem_valid),
        .out_ready  (mem_ready),
        .out_data   (head)
    );

    assign mem_addr = head.addr;
    assign mem_data = head.data;
    assign mem_en   = head.en;

`ifdef EX_MEM_FWD_EN
    function automatic logic fwd_match(entry_t e, logic [ADDR_W-1:0] raddr);
        return e.en && (e.addr == raddr) && (e.addr != ADDR_W'(REG_ZERO));
    endfunction

    // Youngest entry wins, so the tail is examined before the head.
    // NOTE: both outputs get a default before any branch so no latch is
    // inferred on paths that do not assign them.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        if (reset && !flush) begin
            if (tail_valid && fwd_match(tail, id_raddr)) begin
                fwd_hit  = 1'b1;
                fwd_data = tail.data;
            end else if (mem_valid && fwd_match(head, id_raddr)) begin
                fwd_hit  = 1'b1;
                fwd_data = head.data;
            end
        end
    end
`endif

endmodule : ex_mem_stage

// File: tb/tb_ex_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_ex_mem_stage
// Directed self-checking bench for ex_mem_stage. Inputs change 1 time unit
// after a rising edge; outputs are checked in the same window.
// ---------------------------------------------------------------------------
module tb_ex_mem_stage;
    import ex_mem_stage_pkg::*;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              reset;
    logic              flush;
    logic              ex_valid;
    logic              ex_ready;
    logic [ADDR_W-1:0] ex_addr;
    logic [DATA_W-1:0] ex_data;
    logic              ex_en;
    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              mem_en;
`ifdef EX_MEM_FWD_EN
    logic [ADDR_W-1:0] id_raddr;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ex_mem_stage #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .ex_valid  (ex_valid),
        .ex_ready  (ex_ready),
        .ex_addr   (ex_addr),
        .ex_data   (ex_data),
        .ex_en     (ex_en),
`ifdef EX_MEM_FWD_EN
        .id_raddr  (id_raddr),
        .fwd_hit   (fwd_hit),
        .fwd_data  (fwd_data),
`endif
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_en    (mem_en)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input wb_t w);
        ex_valid = v;
        ex_addr  = w.addr;
        ex_data  = w.data;
        ex_en    = w.en;
    endtask

    task automatic check_empty(input string tag);
        check({tag, ".mem_valid"}, mem_valid, 1'b0);
        check({tag, ".mem_addr"},  mem_addr,  '0);
        check({tag, ".mem_data"},  mem_data,  '0);
        check({tag, ".mem_en"},    mem_en,    1'b0);
    endtask

    initial begin
        reset     = 1'b0;
        flush     = 1'b0;
        mem_ready = 1'b0;
        drive(1'b1, '{addr: 5'd9, data: 32'hDEAD_BEEF, en: 1'b1});
`ifdef EX_MEM_FWD_EN
        id_raddr = '0;
`endif
        #2;
        // Reset state; a push held during reset must be dropped.
        check_empty("rst");
        check("rst.ex_ready", ex_ready, 1'b1);
        tick();
        tick();
        check_empty("rst_push_dropped");
        @(negedge clk);
        reset = 1'b1;
        drive(1'b0, WB_NOP);
        tick();

        // --- Single push then pop ---
        mem_ready = 1'b1;
        drive(1'b1, '{addr: 5'd3, data: 32'h0000_00FF, en: 1'b1});
        tick();
        drive(1'b0, WB_NOP);
        check("single.mem_valid", mem_valid, 1'b1);
        check("single.mem_addr",  mem_addr,  5'd3);
        check("single.mem_data",  mem_data,  32'h0000_00FF);
        check("single.mem_en",    mem_en,    1'b1);
        tick();
        check_empty("single_drained");

        // --- Back-pressure: three pushes with mem_ready=0 ---
        mem_ready = 1'b0;
        drive(1'b1, '{addr: 5'd1, data: 32'd1, en: 1'b1});
        check("bp.ready0", ex_ready, 1'b1);
        tick();
        drive(1'b1, '{addr: 5'd2, data: 32'd2, en: 1'b1});
        check("bp.ready1", ex_ready, 1'b1);
        check("bp.head1_early", mem_data, 32'd1);
        tick();
        drive(1'b1, '{addr: 5'd3, data: 32'd3, en: 1'b1});
        check("bp.ready_full", ex_ready, 1'b0);
        tick();
        check("bp.ready_held", ex_ready, 1'b0);
        check("bp.head1", mem_data, 32'd1);
        mem_ready = 1'b1;
        tick();
        check("bp.head2", mem_data, 32'd2);
        check("bp.ready_after_pop", ex_ready, 1'b1);
        tick();
        drive(1'b0, WB_NOP);
        check("bp.head3", mem_data, 32'd3);
        check("bp.addr3", mem_addr, 5'd3);
        tick();
        check_empty("bp_drained");

        // --- Streaming at count=1: data 10..20 ---
        drive(1'b1, '{addr: 5'd4, data: 32'd10, en: 1'b1});
        tick();
        for (int i = 11; i <= 20; i++) begin
            drive(1'b1, '{addr: 5'd4, data: 32'(i), en: 1'b1});
            check($sformatf("stream.valid%0d", i - 1), mem_valid, 1'b1);
            check($sformatf("stream.data%0d",  i - 1), mem_data, 64'(i - 1));
            check($sformatf("stream.ready%0d", i - 1), ex_ready, 1'b1);
            tick();
        end
        drive(1'b0, WB_NOP);
        check("stream.data20", mem_data, 32'd20);
        tick();
        check_empty("stream_drained");

        // --- en=0 entries are delivered as no-ops ---
        drive(1'b1, '{addr: 5'd4, data: 32'h1234, en: 1'b0});
        tick();
        drive(1'b0, WB_NOP);
        check("noop.mem_valid", mem_valid, 1'b1);
        check("noop.mem_en",    mem_en,    1'b0);
        check("noop.mem_data",  mem_data,  32'h1234);
        tick();
        check_empty("noop_drained");

        // --- Flush with count=2 and a coincident push ---
        mem_ready = 1'b0;
        drive(1'b1, '{addr: 5'd7, data: 32'h40, en: 1'b1});
        tick();
        drive(1'b1, '{addr: 5'd7, data: 32'h41, en: 1'b1});
        tick();
        check("flush.full", ex_ready, 1'b0);
`ifdef EX_MEM_FWD_EN
        // Older {7,0x40}, younger {7,0x41}: youngest wins.
        id_raddr = 5'd7;
        #1;
        check("fwd.hit_young",  fwd_hit,  1'b1);
        check("fwd.data_young", fwd_data, 32'h41);
        id_raddr = 5'd0;
        #1;
        check("fwd.r0_hit",  fwd_hit,  1'b0);
        check("fwd.r0_data", fwd_data, 32'h0);
        id_raddr = 5'd7;
`endif
        flush     = 1'b1;
        mem_ready = 1'b1;
        drive(1'b1, '{addr: 5'd8, data: 32'h42, en: 1'b1});
`ifdef EX_MEM_FWD_EN
        #1;
        check("fwd.flush_hit",  fwd_hit,  1'b0);
        check("fwd.flush_data", fwd_data, 32'h0);
`endif
        tick();
        flush = 1'b0;
        drive(1'b0, WB_NOP);
        check_empty("flush");
        check("flush.ex_ready", ex_ready, 1'b1);
        tick();
        check_empty("flush_no_ghost");

`ifdef EX_MEM_FWD_EN
        // Disabled write to a matching address never forwards.
        mem_ready = 1'b0;
        drive(1'b1, '{addr: 5'd6, data: 32'hC0C0, en: 1'b0});
        id_raddr = 5'd6;
        tick();
        drive(1'b0, WB_NOP);
        check("fwd.en0_hit",  fwd_hit,  1'b0);
        check("fwd.en0_data", fwd_data, 32'h0);
        mem_ready = 1'b1;
        tick();
        check_empty("fwd_drained");
`endif

        // --- Asynchronous reset mid-cycle with count=2 ---
        mem_ready = 1'b0;
        drive(1'b1, '{addr: 5'd10, data: 32'h50, en: 1'b1});
        tick();
        drive(1'b1, '{addr: 5'd11, data: 32'h51, en: 1'b1});
        tick();
        drive(1'b0, WB_NOP);
        check("arst.pre_full", ex_ready, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check_empty("arst");
        check("arst.ex_ready", ex_ready, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        drive(1'b1, '{addr: 5'd9, data: 32'h60, en: 1'b1});
        tick();
        drive(1'b0, WB_NOP);
        check("arst.post_valid", mem_valid, 1'b1);
        check("arst.post_addr",  mem_addr,  5'd9);
        check("arst.post_data",  mem_data,  32'h60);
        mem_ready = 1'b1;
        tick();
        check_empty("arst_drained");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Safety bound so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule : tb_ex_mem_stage
